mem_stage: RTL

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_pkg.sv | 22 ++
 rtl/mem_stage_if.sv | 30 +++
 rtl/mem_timeout_counter.sv | 32 +++
 rtl/mem_stage.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared pipeline constants: opcodes, MEM-stage FSM encoding and the word
// alignment mask used by the data-memory access path.
package mem_stage_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_e;

    localparam logic [1:0] ALIGN_MASK = 2'b11;

    function automatic logic is_word_aligned(input logic [31:0] addr);
        return ((addr[1:0] & ALIGN_MASK) == 2'b00);
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage (master) and
// the data memory (slave).
interface mem_stage_if;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_ack,
        output mem_rdata
    );

endinterface

// File: rtl/mem_timeout_counter.sv
// Cycle counter for the MEM-stage wait state; terminal flags the last
// cycle allowed before the outstanding request is abandoned.
module mem_timeout_counter #(
    parameter int TIMEOUT = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] count_r;

    // Count register: clear has priority over enable.
    always_ff @(posedge clock) begin
        if (!reset) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            count_r <= {CNT_W{1'b0}};
        end else if (enable) begin
            count_r <= count_r + CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign terminal = (count_r == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: forwards ALU results, issues word-aligned loads/stores
// to data memory, stalls upstream while waiting, and aborts on timeout.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic [31:0] ex_alu_result,
    input  logic [31:0] ex_store_data,
    input  logic [4:0]  ex_write_reg,
    input  logic        ex_RegWrite,
    input  logic        ex_MemRead,
    input  logic        ex_MemWrite,
    input  logic        ex_MemToReg,
    mem_stage_if.master mem,
    output logic        stall,
    output logic        wb_valid,
    output logic        wb_RegWrite,
    output logic [4:0]  wb_write_reg,
    output logic [31:0] wb_write_data,
    output logic        err
);

    mem_state_e  state_r;
    mem_state_e  state_nxt_s;

    logic        req_r,          req_nxt_s;
    logic        we_r,           we_nxt_s;
    logic [31:0] addr_r,         addr_nxt_s;
    logic [31:0] wdata_r,        wdata_nxt_s;
    logic [4:0]  lat_wreg_r,     lat_wreg_nxt_s;
    logic        lat_regwrite_r, lat_regwrite_nxt_s;
    logic        lat_memtoreg_r, lat_memtoreg_nxt_s;

    logic        wb_valid_r,      wb_valid_nxt_s;
    logic        wb_regwrite_r,   wb_regwrite_nxt_s;
    logic [4:0]  wb_write_reg_r,  wb_write_reg_nxt_s;
    logic [31:0] wb_write_data_r, wb_write_data_nxt_s;
    logic        err_r,           err_nxt_s;

    logic        mem_op_s;
    logic        illegal_s;
    logic        cnt_clear_s;
    logic        cnt_enable_s;
    logic        terminal_s;

    // Exactly one access type is a memory op; both set, or a misaligned
    // access, is rejected without touching the bus.
    assign mem_op_s  = ex_MemRead ^ ex_MemWrite;
    assign illegal_s = (ex_MemRead & ex_MemWrite) |
                       ((ex_MemRead | ex_MemWrite) & ~is_word_aligned(ex_alu_result));

    assign cnt_clear_s  = (state_r != WAIT);
    assign cnt_enable_s = (state_r == WAIT) & ~mem.mem_ack & ~terminal_s;

    mem_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clock    (clock),
        .reset    (reset),
        .clear    (cnt_clear_s),
        .enable   (cnt_enable_s),
        .terminal (terminal_s)
    );

    // Next-state and next-output logic for the IDLE/WAIT controller.
    always_comb begin
        state_nxt_s         = state_r;
        req_nxt_s           = req_r;
        we_nxt_s            = we_r;
        addr_nxt_s          = addr_r;
        wdata_nxt_s         = wdata_r;
        lat_wreg_nxt_s      = lat_wreg_r;
        lat_regwrite_nxt_s  = lat_regwrite_r;
        lat_memtoreg_nxt_s  = lat_memtoreg_r;
        wb_valid_nxt_s      = 1'b0;
        wb_regwrite_nxt_s   = 1'b0;
        wb_write_reg_nxt_s  = wb_write_reg_r;
        wb_write_data_nxt_s = wb_write_data_r;
        err_nxt_s           = err_r;

        case (state_r)
            IDLE: begin
                if (!ex_valid) begin
                    wb_valid_nxt_s = 1'b0;
                end else if (illegal_s) begin
                    err_nxt_s           = 1'b1;
                    wb_valid_nxt_s      = 1'b1;
                    wb_regwrite_nxt_s   = 1'b0;
                    wb_write_reg_nxt_s  = ex_write_reg;
                    wb_write_data_nxt_s = ex_alu_result;
                end else if (mem_op_s) begin
                    state_nxt_s        = WAIT;
                    req_nxt_s          = 1'b1;
                    we_nxt_s           = ex_MemWrite;
                    addr_nxt_s         = ex_alu_result;
                    wdata_nxt_s        = ex_store_data;
                    lat_wreg_nxt_s     = ex_write_reg;
                    lat_regwrite_nxt_s = ex_RegWrite;
                    lat_memtoreg_nxt_s = ex_MemToReg;
                end else begin
                    wb_valid_nxt_s      = 1'b1;
                    wb_regwrite_nxt_s   = ex_RegWrite;
                    wb_write_reg_nxt_s  = ex_write_reg;
                    wb_write_data_nxt_s = ex_alu_result;
                end
            end
            WAIT: begin
                // An ack landing on the terminal cycle still completes normally.
                if (mem.mem_ack) begin
                    state_nxt_s         = IDLE;
                    req_nxt_s           = 1'b0;
                    wb_valid_nxt_s      = 1'b1;
                    wb_regwrite_nxt_s   = lat_regwrite_r & ~we_r;
                    wb_write_reg_nxt_s  = lat_wreg_r;
                    wb_write_data_nxt_s = lat_memtoreg_r ? mem.mem_rdata : addr_r;
                end else if (terminal_s) begin
                    state_nxt_s         = IDLE;
                    req_nxt_s           = 1'b0;
                    err_nxt_s           = 1'b1;
                    wb_valid_nxt_s      = 1'b1;
                    wb_regwrite_nxt_s   = 1'b0;
                    wb_write_reg_nxt_s  = lat_wreg_r;
                    wb_write_data_nxt_s = addr_r;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                req_nxt_s   = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any outstanding request.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r         <= IDLE;
            req_r           <= 1'b0;
            we_r            <= 1'b0;
            addr_r          <= 32'h0000_0000;
            wdata_r         <= 32'h0000_0000;
            lat_wreg_r      <= 5'd0;
            lat_regwrite_r  <= 1'b0;
            lat_memtoreg_r  <= 1'b0;
            wb_valid_r      <= 1'b0;
            wb_regwrite_r   <= 1'b0;
            wb_write_reg_r  <= 5'd0;
            wb_write_data_r <= 32'h0000_0000;
            err_r           <= 1'b0;
        end else begin
            state_r         <= state_nxt_s;
            req_r           <= req_nxt_s;
            we_r            <= we_nxt_s;
            addr_r          <= addr_nxt_s;
            wdata_r         <= wdata_nxt_s;
            lat_wreg_r      <= lat_wreg_nxt_s;
            lat_regwrite_r  <= lat_regwrite_nxt_s;
            lat_memtoreg_r  <= lat_memtoreg_nxt_s;
            wb_valid_r      <= wb_valid_nxt_s;
            wb_regwrite_r   <= wb_regwrite_nxt_s;
            wb_write_reg_r  <= wb_write_reg_nxt_s;
            wb_write_data_r <= wb_write_data_nxt_s;
            err_r           <= err_nxt_s;
        end
    end

    assign stall         = (state_r == WAIT);
    assign mem.mem_req   = req_r;
    assign mem.mem_we    = we_r;
    assign mem.mem_addr  = addr_r;
    assign mem.mem_wdata = wdata_r;
    assign wb_valid      = wb_valid_r;
    assign wb_RegWrite   = wb_regwrite_r;
    assign wb_write_reg  = wb_write_reg_r;
    assign wb_write_data = wb_write_data_r;
    assign err           = err_r;

endmodule
